// File: rtl/air_hockey_pkg.sv
// Shared air-hockey definitions: FSM state encoding, screen geometry,
// coordinate widths and the colour constants used by the drawing engines.
package air_hockey_pkg;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;

  localparam int unsigned X_W      = 8;
  localparam int unsigned Y_W      = 7;
  localparam int unsigned COLOUR_W = 3;

  localparam logic [COLOUR_W-1:0] BG_COLOUR   = 3'b000;
  localparam logic [COLOUR_W-1:0] PUCK_COLOUR = 3'b111;

  typedef enum logic [2:0] {
    IDLE,
    ERASE,
    MOVE,
    DRAW,
    DONE
  } state_t;

endpackage

// File: rtl/puck_motion_engine_if.sv
// Pixel-write bus towards the VGA adapter.
//   plot       : pixel write strobe
//   x_out      : pixel x
//   y_out      : pixel y
//   colour_out : pixel colour
// master = pixel producer (drawing engine), slave = VGA adapter.
interface puck_motion_engine_if;
  import air_hockey_pkg::*;

  logic                plot;
  logic [X_W-1:0]      x_out;
  logic [Y_W-1:0]      y_out;
  logic [COLOUR_W-1:0] colour_out;

  modport master (output plot, x_out, y_out, colour_out);
  modport slave  (input  plot, x_out, y_out, colour_out);

endinterface

// File: rtl/square_scan.sv
// Row-major pixel scanner for a square of side 2**SIDE_LOG2.
//   clock, resetn : clock and synchronous active-high reset
//   start         : restart the scan at (0,0)
//   enable        : advance one pixel this cycle
//   dx, dy        : current offset inside the square (dx varies fastest)
//   last_c        : current pixel is the final one of the square
// The counter wraps to zero after the final pixel, so a scan that runs to
// completion leaves it ready for the next one.
module square_scan #(
  parameter int unsigned SIDE_LOG2 = 2
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 start,
  input  logic                 enable,
  output logic [SIDE_LOG2-1:0] dx,
  output logic [SIDE_LOG2-1:0] dy,
  output logic                 last_c
);

  localparam int unsigned CNT_W = 2 * SIDE_LOG2;

  logic [CNT_W-1:0] count;

  // Pixel counter: low half is dx, high half is dy.
  always_ff @(posedge clock) begin
    if (resetn) begin
      count <= '0;
    end else if (start) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign dx     = count[SIDE_LOG2-1:0];
  assign dy     = count[CNT_W-1:SIDE_LOG2];
  assign last_c = &count;

endmodule

// File: rtl/puck_motion_engine.sv
// Per-frame puck update: on an accepted frame tick it erases the old puck
// square, steps the puck one pixel per axis with wall reflection, redraws the
// square at the new position and pulses done.
//   clock, resetn      : clock and synchronous active-high reset
//   enable             : 0 blocks new frame updates (a running one completes)
//   frame_tick         : one-cycle frame pulse from the pacing counter
//   vga                : pixel write bus (plot, x_out, y_out, colour_out)
//   puck_x, puck_y     : puck top-left position
//   dir_x, dir_y       : 1 = moving towards +x / +y
//   busy               : update in progress
//   done               : one-cycle pulse when the update finishes
//   overrun            : sticky, a frame tick arrived while busy
module puck_motion_engine #(
  parameter int unsigned SCREEN_W    = air_hockey_pkg::SCREEN_W,
  parameter int unsigned SCREEN_H    = air_hockey_pkg::SCREEN_H,
  parameter int unsigned PUCK_SIZE   = 4,
  parameter int unsigned X_INIT      = 78,
  parameter int unsigned Y_INIT      = 58,
  parameter logic [2:0]  BG_COLOUR   = air_hockey_pkg::BG_COLOUR,
  parameter logic [2:0]  PUCK_COLOUR = air_hockey_pkg::PUCK_COLOUR
) (
  input  logic                             clock,
  input  logic                             resetn,
  input  logic                             enable,
  input  logic                             frame_tick,
  puck_motion_engine_if.master             vga,
  output logic [air_hockey_pkg::X_W-1:0]   puck_x,
  output logic [air_hockey_pkg::Y_W-1:0]   puck_y,
  output logic                             dir_x,
  output logic                             dir_y,
  output logic                             busy,
  output logic                             done,
  output logic                             overrun
);
  import air_hockey_pkg::*;

  localparam int unsigned SIDE_LOG2 = $clog2(PUCK_SIZE);
  localparam int unsigned X_MAX     = SCREEN_W - PUCK_SIZE;
  localparam int unsigned Y_MAX     = SCREEN_H - PUCK_SIZE;

  state_t                 state;
  logic                   plot_q;
  logic [COLOUR_W-1:0]    colour_q;
  logic [SIDE_LOG2-1:0]   dx;
  logic [SIDE_LOG2-1:0]   dy;
  logic                   scan_last_c;
  logic                   scan_start_c;
  logic                   tick_accept_c;

  assign tick_accept_c = (state == IDLE) && frame_tick && enable;
  // Restart the scan on entry to each square pass.
  assign scan_start_c  = tick_accept_c || (state == MOVE);

  square_scan #(
    .SIDE_LOG2 (SIDE_LOG2)
  ) u_scan (
    .clock  (clock),
    .resetn (resetn),
    .start  (scan_start_c),
    .enable (plot_q),
    .dx     (dx),
    .dy     (dy),
    .last_c (scan_last_c)
  );

  // Pixel address is always relative to the current (old during erase, new
  // during draw) puck position.
  assign vga.plot       = plot_q;
  assign vga.colour_out = colour_q;
  assign vga.x_out      = puck_x + X_W'(dx);
  assign vga.y_out      = puck_y + Y_W'(dy);

  // Frame update sequencer with registered outputs.
  always_ff @(posedge clock) begin
    if (resetn) begin
      state    <= IDLE;
      puck_x   <= X_W'(X_INIT);
      puck_y   <= Y_W'(Y_INIT);
      dir_x    <= 1'b1;
      dir_y    <= 1'b1;
      plot_q   <= 1'b0;
      colour_q <= BG_COLOUR;
      busy     <= 1'b0;
      done     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      done <= 1'b0;

      // Ticks arriving mid-update are dropped, only remembered here.
      if (frame_tick && busy) begin
        overrun <= 1'b1;
      end

      unique case (state)
        IDLE: begin
          if (tick_accept_c) begin
            state    <= ERASE;
            plot_q   <= 1'b1;
            colour_q <= BG_COLOUR;
            busy     <= 1'b1;
          end
        end

        ERASE: begin
          if (scan_last_c) begin
            state  <= MOVE;
            plot_q <= 1'b0;
          end
        end

        MOVE: begin
          state    <= DRAW;
          plot_q   <= 1'b1;
          colour_q <= PUCK_COLOUR;

          // x axis: reflect off the right or left wall, else step.
          if (dir_x && (puck_x == X_W'(X_MAX))) begin
            dir_x  <= 1'b0;
            puck_x <= puck_x - X_W'(1);
          end else if (!dir_x && (puck_x == '0)) begin
            dir_x  <= 1'b1;
            puck_x <= X_W'(1);
          end else if (dir_x) begin
            puck_x <= puck_x + X_W'(1);
          end else begin
            puck_x <= puck_x - X_W'(1);
          end

          // y axis: reflect off the bottom or top wall, else step.
          if (dir_y && (puck_y == Y_W'(Y_MAX))) begin
            dir_y  <= 1'b0;
            puck_y <= puck_y - Y_W'(1);
          end else if (!dir_y && (puck_y == '0)) begin
            dir_y  <= 1'b1;
            puck_y <= Y_W'(1);
          end else if (dir_y) begin
            puck_y <= puck_y + Y_W'(1);
          end else begin
            puck_y <= puck_y - Y_W'(1);
          end
        end

        DRAW: begin
          if (scan_last_c) begin
            state  <= DONE;
            plot_q <= 1'b0;
            done   <= 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
